// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor D = A - B: one full-subtractor cell reused for WIDTH cycles, LSB first.
// Optional signed-overflow output V is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic cell_a, cell_b, cell_d, cell_bo, last_bit;

  assign cell_a   = sa[0];
  assign cell_b   = sb[0];
  assign cell_d   = cell_a ^ cell_b ^ br;
  assign cell_bo  = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // On the final slice the operand LSBs are the captured MSBs, so the cell inputs feed V directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      V    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa  <= A;
            sb  <= B;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {cell_d, res[WIDTH-1:1]};
          br  <= cell_bo;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            D    <= {cell_d, res[WIDTH-1:1]};
            Bout <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            V    <= (cell_a != cell_b) && (cell_d != cell_a);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: 8-bit instance for protocol checks, 2-bit instance swept exhaustively.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start2;
  logic [7:0] a8, b8, d8;
  logic [1:0] a2, b2, d2;
  logic       busy8, done8, bout8;
  logic       busy2, done2, bout2;
`ifdef SERIAL_SUB_OVF_EN
  logic       v8, v2;
`endif

  int compare_count  = 0;
  int mismatch_count = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .V(v8)
`endif
  );

  serial_subtractor_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .D(d2), .Bout(bout2)
`ifdef SERIAL_SUB_OVF_EN
    , .V(v2)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request to the 8-bit instance; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a_val, input logic [7:0] b_val);
    @(negedge clk);
    a8 = a_val; b8 = b_val; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a_val; b8 = ~b_val;
  endtask

  // Waits for done (bounded), then checks latency, result, and the one-cycle pulse.
  task automatic wait_and_check8(input string tag, input logic [7:0] exp_d, input logic exp_bout);
    int edges = 0;
    checkOutput({tag, "_busy_run"}, 32'(busy8), 32'd1);
    while (!done8 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done8), 32'd1);
    checkOutput({tag, "_latency"}, 32'(edges), 32'd8);
    checkOutput({tag, "_D"}, 32'(d8), 32'(exp_d));
    checkOutput({tag, "_Bout"}, 32'(bout8), 32'(exp_bout));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done8), 32'd0);
    checkOutput({tag, "_busy_idle"}, 32'(busy8), 32'd0);
    checkOutput({tag, "_D_held"}, 32'(d8), 32'(exp_d));
  endtask

  initial begin
    int done_hits;
    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_D", 32'(d8), 32'd0);
    checkOutput("rst_Bout", 32'(bout8), 32'd0);
    checkOutput("rst_busy2", 32'(busy2), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("rst_V", 32'(v8), 32'd0);
`endif
    rst = 1'b0;

    applyStimulus(8'h5A, 8'h3C); wait_and_check8("basic", 8'h1E, 1'b0);
    applyStimulus(8'h00, 8'h01); wait_and_check8("wrap", 8'hFF, 1'b1);
    applyStimulus(8'hFF, 8'hFF); wait_and_check8("equal", 8'h00, 1'b0);
    applyStimulus(8'h20, 8'hC3); wait_and_check8("mixed", 8'h5D, 1'b1);

    // Busy lockout: extra starts at cycles 3 and 8 of the run must be ignored.
    applyStimulus(8'h10, 8'h01);
    done_hits = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 8) begin a8 = 8'h00; b8 = 8'h00; start8 = 1'b1; end
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        done_hits++;
        checkOutput("lock_D", 32'(d8), 32'h0F);
      end
    end
    checkOutput("lock_single_done", 32'(done_hits), 32'd1);
    checkOutput("lock_busy_after", 32'(busy8), 32'd0);

    // start held high: re-accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    a8 = 8'h07; b8 = 8'h02; start8 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 8; c++) @(negedge clk);
    checkOutput("b2b_done", 32'(done8), 32'd1);
    checkOutput("b2b_D", 32'(d8), 32'h05);
    @(negedge clk);
    checkOutput("b2b_idle_gap", 32'(busy8), 32'd0);
    @(negedge clk);
    checkOutput("b2b_reaccept", 32'(busy8), 32'd1);
    start8 = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    checkOutput("b2b_second_done", 32'(done8), 32'd1);
    @(negedge clk);

    // Reset during RUN discards the operation.
    applyStimulus(8'h77, 8'h11);
    repeat (3) @(negedge clk);
    rst = 1'b1; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    checkOutput("midrst_busy", 32'(busy8), 32'd0);
    checkOutput("midrst_done", 32'(done8), 32'd0);
    checkOutput("midrst_D", 32'(d8), 32'd0);
    checkOutput("midrst_Bout", 32'(bout8), 32'd0);
    done_hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) done_hits++;
    end
    checkOutput("midrst_no_done", 32'(done_hits), 32'd0);
    applyStimulus(8'h09, 8'h03); wait_and_check8("after_rst", 8'h06, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    applyStimulus(8'h80, 8'h01); wait_and_check8("ovf_pos", 8'h7F, 1'b0);
    checkOutput("ovf_V1", 32'(v8), 32'd1);
    applyStimulus(8'h05, 8'h03); wait_and_check8("ovf_none", 8'h02, 1'b0);
    checkOutput("ovf_V0", 32'(v8), 32'd0);
`endif

    // Exhaustive 2-bit sweep.
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        int edges;
        logic [1:0] exp_d;
        exp_d = 2'(ia - ib);
        @(negedge clk);
        a2 = 2'(ia); b2 = 2'(ib); start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; a2 = 2'(~ia); b2 = 2'(~ib);
        edges = 0;
        while (!done2 && edges < 20) begin
          @(negedge clk);
          edges++;
        end
        checkOutput($sformatf("w2_%0d_%0d_latency", ia, ib), 32'(edges), 32'd2);
        checkOutput($sformatf("w2_%0d_%0d_D", ia, ib), 32'(d2), 32'(exp_d));
        checkOutput($sformatf("w2_%0d_%0d_Bout", ia, ib), 32'(bout2), 32'(ia < ib));
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
